// File: rtl/lc3_seg_pkg.sv
// Shared constants for the seven-segment scan path: hex font, segment bit positions
// and the pin idle-level helper. No logic, so there is no latency.
// There is no flow control here. Every consumer reads these values combinationally.
package lc3_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high a..g patterns. Entry 0 is the rightmost element, so HEX_FONT[n] is the glyph for n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Idle level of a pin. An active-low pin idles high.
  function automatic logic inactive_level(input logic active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Maps a nibble and a dp flag to an active-high 8-bit segment pattern.
// Latency: purely combinational, zero cycles.
// There is no flow control. The output follows the inputs.
module seg_hex_decoder
  import lc3_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  // Look up the glyph and place the dp in its bit.
  always_comb begin
    seg_o                = '0;
    seg_o[SEG_G:SEG_A]   = HEX_FONT[nibble_i];
    seg_o[SEG_DP]        = dp_i;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with a double-buffered value, frame-synchronous load and ack.
// Latency: segment and select pins are registered, so they are 1 clock behind digit_idx and the active regs.
// Loads are never refused. A newer load overwrites the pending one, and a single ack fires when it is shown.
module seg_scan_driver
  import lc3_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 2,
  parameter int BLINK_DIV      = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  load_ack,
  output logic                  frame_tick,
  output logic [7:0]            seg_output_single,
  output logic [DIGITS-1:0]     seg_output_sequence
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FC_W  = $clog2(2 * BLINK_DIV);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_vld_q, pend_vld_d;
  logic                load_ack_q, load_ack_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic                scan_tick, boundary, blink_phase;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blink, cur_lz, lead_zero;
  logic [DIGITS-1:0]   sel_hi;
  logic [7:0]          dec_seg, pat;

  assign scan_tick   = (div_cnt_q == DIV_W'(DIV - 1));
  assign boundary    = scan_tick && (digit_idx_q == IDX_W'(DIGITS - 1));
  assign blink_phase = (frame_cnt_q >= FC_W'(BLINK_DIV));

  // Next-state logic for the scan counters and the pending/active buffers.
  always_comb begin
    div_cnt_d   = div_cnt_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    frame_cnt_d = frame_cnt_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_vld_d  = pend_vld_q;
    load_ack_d  = 1'b0;

    if (scan_tick) begin
      div_cnt_d   = '0;
      digit_idx_d = boundary ? '0 : digit_idx_q + IDX_W'(1);
    end

    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end

    // A load in the boundary cycle is newer than anything pending, so it goes straight to the active regs.
    if (boundary) begin
      frame_cnt_d = (frame_cnt_q == FC_W'(2 * BLINK_DIV - 1)) ? '0 : frame_cnt_q + FC_W'(1);
      if (load) begin
        act_val_d = value_in;
        act_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      load_ack_d = load || pend_vld_q;
      pend_vld_d = 1'b0;
    end
  end

  // Select the current digit and compute leading-zero blanking, scanning from the top digit down.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    lead_zero = 1'b1;
    sel_hi    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero && (act_val_q[i*4 +: 4] == 4'h0);
      if (digit_idx_q == IDX_W'(i)) begin
        cur_nib   = act_val_q[i*4 +: 4];
        cur_dp    = act_dp_q[i];
        cur_blink = blink_mask[i];
        cur_lz    = blank_lz && lead_zero && (i != 0);
        sel_hi[i] = 1'b1;
      end
    end
  end

  seg_hex_decoder u_dec (
    .nibble_i (cur_nib),
    .dp_i     (cur_dp),
    .seg_o    (dec_seg)
  );

  // Blink hides the dp as well. A leading-zero blank keeps the dp.
  always_comb begin
    if (blink_phase && cur_blink) begin
      pat = 8'h00;
    end else if (cur_lz) begin
      pat = {cur_dp, 7'h00};
    end else begin
      pat = dec_seg;
    end
    seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
    sel_d = AN_ACTIVE_LOW ? ~sel_hi : sel_hi;
  end

  // State and pin registers. Reset drops any pending load and parks the pins at their idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      frame_cnt_q <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_vld_q  <= 1'b0;
      load_ack_q  <= 1'b0;
      seg_q       <= {8{inactive_level(SEG_ACTIVE_LOW)}};
      sel_q       <= {DIGITS{inactive_level(AN_ACTIVE_LOW)}};
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      frame_cnt_q <= frame_cnt_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_vld_q  <= pend_vld_d;
      load_ack_q  <= load_ack_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign frame_tick          = boundary && !rst;
  assign load_ack            = load_ack_q;
  assign seg_output_single   = seg_q;
  assign seg_output_sequence = sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, DIV=2, BLINK_DIV=2, active-low pins.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled at the same point.
// There is no flow control. Every wait on a DUT event is bounded.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic        load_ack, frame_tick;
  logic [7:0]  seg_output_single;
  logic [3:0]  seg_output_sequence;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  disp [4];

  seg_scan_driver #(
    .DIGITS(4), .DIV(2), .BLINK_DIV(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .value_in            (value_in),
    .dp_in               (dp_in),
    .load                (load),
    .blank_lz            (blank_lz),
    .blink_mask          (blink_mask),
    .load_ack            (load_ack),
    .frame_tick          (frame_tick),
    .seg_output_single   (seg_output_single),
    .seg_output_sequence (seg_output_sequence)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Stops in the cycle where frame_tick is high.
  task automatic wait_frame();
    int seen;
    seen = 0;
    for (int n = 0; n < 40 && seen == 0; n++) begin
      step();
      if (frame_tick) seen = 1;
    end
    check("frame_tick_seen", seen, 1);
  endtask

  // Leaves the DUT at digit 0, slot 0 of a new frame.
  task automatic sync_frame();
    wait_frame();
    step();
  endtask

  // Must start at digit 0, slot 0. Records one full frame into disp and ends at the start of the next frame.
  task automatic capture_frame(input string tag);
    int bad;
    int found;
    logic [3:0] oh;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      found = 0;
      for (int i = 0; i < 4; i++) begin
        oh = 4'(1) << i;
        if (seg_output_sequence == ~oh) begin
          disp[i] = seg_output_single;
          found   = 1;
        end
      end
      if (found == 0) bad++;
    end
    check({tag, "_sel_onehot"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks;

    // Reset
    step(); step(); step();
    check("rst_seg", seg_output_single, 8'hFF);
    check("rst_sel", seg_output_sequence, 4'hF);
    check("rst_ack", load_ack, 1'b0);
    check("rst_ftick", frame_tick, 1'b0);
    rst = 1'b0;
    step();
    check("rel_sel", seg_output_sequence, 4'b1110);
    check("rel_seg", seg_output_single, 8'hC0);

    // Frame-synchronous load issued while digit 1 is being scanned
    step();
    do_load(16'h12A4, 4'h0);
    check("pre_seg", seg_output_single, 8'hC0);
    check("pre_sel", seg_output_sequence, 4'b1101);
    wait_frame();
    check("ack_at_tick", load_ack, 1'b0);
    step();
    check("ack_after_tick", load_ack, 1'b1);
    check("old_digit3", seg_output_single, 8'hC0);
    capture_frame("load");
    check("load_d0", disp[0], 8'h99);
    check("load_d1", disp[1], 8'h88);
    check("load_d2", disp[2], 8'hA4);
    check("load_d3", disp[3], 8'hF9);
    check("ack_single", load_ack, 1'b0);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0030, 4'h0);
    sync_frame();
    capture_frame("lz");
    check("lz_d3", disp[3], 8'hFF);
    check("lz_d2", disp[2], 8'hFF);
    check("lz_d1", disp[1], 8'hB0);
    check("lz_d0", disp[0], 8'hC0);
    do_load(16'h0000, 4'h0);
    sync_frame();
    capture_frame("lz0");
    check("lz0_d3", disp[3], 8'hFF);
    check("lz0_d2", disp[2], 8'hFF);
    check("lz0_d1", disp[1], 8'hFF);
    check("lz0_d0", disp[0], 8'hC0);
    blank_lz = 1'b0;

    // Two loads in one frame
    do_load(16'h1111, 4'h0);
    step(); step();
    do_load(16'h2222, 4'h0);
    acks = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      if (load_ack) acks++;
    end
    check("coll_acks", acks, 1);
    sync_frame();
    capture_frame("coll");
    for (int i = 0; i < 4; i++) check($sformatf("coll_d%0d", i), disp[i], 8'hA4);

    // Load in the same cycle as frame_tick
    wait_frame();
    value_in = 16'h3456;
    dp_in    = 4'h0;
    load     = 1'b1;
    step();
    load     = 1'b0;
    check("coinc_ack", load_ack, 1'b1);
    check("coinc_old_d3", seg_output_single, 8'hA4);
    capture_frame("coinc");
    check("coinc_d0", disp[0], 8'h82);
    check("coinc_d1", disp[1], 8'h92);
    check("coinc_d2", disp[2], 8'h99);
    check("coinc_d3", disp[3], 8'hB0);
    check("coinc_ack_drop", load_ack, 1'b0);

    // Reset while a load is pending
    do_load(16'h1234, 4'h0);
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("mrst_seg", seg_output_single, 8'hC0);
    check("mrst_sel", seg_output_sequence, 4'b1110);
    acks = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (load_ack) acks++;
    end
    check("mrst_acks", acks, 0);
    sync_frame();
    capture_frame("mrst");
    check("mrst_d1", disp[1], 8'hC0);
    check("mrst_d3", disp[3], 8'hC0);

    // Blink: mask digit 0, with its dp set
    rst = 1'b1;
    blink_mask = 4'b0001;
    step(); step();
    rst = 1'b0;
    step();
    do_load(16'h0000, 4'b0001);
    sync_frame();
    capture_frame("blink_f1");
    check("blink_f1_d0", disp[0], 8'h40);
    capture_frame("blink_f2");
    check("blink_f2_d0", disp[0], 8'hFF);
    check("blink_f2_d1", disp[1], 8'hC0);
    capture_frame("blink_f3");
    check("blink_f3_d0", disp[0], 8'hFF);
    capture_frame("blink_f4");
    check("blink_f4_d0", disp[0], 8'h40);
    blink_mask = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
